wb_sdram_arbiter: RTL and testbench
===================================

# wb_sdram_arbiter

Two-master Wishbone (pipelined) arbiter that shares the single Wishbone slave port of the `sdram` controller between two requesters: master 0 is the USB-to-SDRAM write path and master 1 is the SDRAM-to-USB read path. It holds a grant for the whole bus cycle (`cyc` high), alternates between masters round-robin when both contend, and tracks outstanding transfers. An optional watchdog aborts a cycle that the slave never acknowledges. It sits between the USB FIFO state machine and `u_sdram`, on `USB_IFCLK`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles without ack, with transfers outstanding, before an abort (watchdog only).
- `OUTST_W`, default 3: width of the outstanding-transfer counter. Maximum outstanding is 2^OUTST_W − 1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i`, in, 1: clock (`USB_IFCLK`).
  - `rst_i`, in, 1: synchronous, active-high reset.
- Master ports, `mN_*` with N = 0, 1:
  - `mN_cyc_i`, in, 1
  - `mN_stb_i`, in, 1
  - `mN_we_i`, in, 1
  - `mN_sel_i`, in, 4
  - `mN_addr_i`, in, 32
  - `mN_data_i`, in, 32: write data.
  - `mN_data_o`, out, 32: read data.
  - `mN_stall_o`, out, 1
  - `mN_ack_o`, out, 1
  - `mN_err_o`, out, 1: timeout abort pulse.
- Slave port, to `u_sdram`:
  - `s_cyc_o`, out, 1
  - `s_stb_o`, out, 1
  - `s_we_o`, out, 1
  - `s_sel_o`, out, 4
  - `s_addr_o`, out, 32
  - `s_data_o`, out, 32
  - `s_data_i`, in, 32
  - `s_stall_i`, in, 1
  - `s_ack_i`, in, 1

## Operation
- States: IDLE, OWN0, OWN1, DRAIN0, DRAIN1. The state, last-grant pointer `last`, outstanding counter `outst` and watchdog counter are registered.
- Reset values: state = IDLE, `last` = 1 (master 0 wins the first contention), `outst` = 0, watchdog = 0.
- IDLE:
  - If exactly one `mN_cyc_i` is high, go to OWNN.
  - If both are high, go to OWN(~`last`).
  - Otherwise stay in IDLE.
- OWNN:
  - Slave outputs follow master N combinationally: `s_cyc_o`/`s_stb_o`/`s_we_o`/`s_sel_o`/`s_addr_o`/`s_data_o` = `mN_*`.
  - `mN_stall_o` = `s_stall_i`; `mN_ack_o` = `s_ack_i`.
  - `last` is set to N on entry.
- Release from OWNN when `mN_cyc_i` = 0:
  - If the other master's cyc is high, hand over directly to OWN(other) on the next cycle.
  - Otherwise go to IDLE.
- Non-owner masters, and both masters in IDLE and DRAIN: `stall_o` = 1, `ack_o` = 0.
- Slave outputs in IDLE and DRAIN are all 0, including `s_cyc_o` and `s_stb_o`.
- `m0_data_o` = `m1_data_o` = `s_data_i` always (broadcast). Qualify read data with `ack_o`.
- Outstanding counter:
  - Increments on `s_stb_o & ~s_stall_i`.
  - Decrements on `s_ack_i` while owned.
  - Simultaneous increment and decrement leaves it unchanged.
  - Saturates: at 2^OUTST_W − 1 the arbiter forces `mN_stall_o` = 1.
  - Cleared on entry to IDLE.
- Protocol rule on masters: `cyc` must stay high until `outst` = 0.
  - If cyc drops with `outst` ≠ 0, the grant is still released and `outst` is cleared.
  - Late acks arriving in IDLE are discarded and never forwarded.
- Reset asserted mid-cycle returns to the IDLE reset values on the next edge. `s_cyc_o` is 0 in the cycle after reset is sampled.

## Timing
- Grant latency: `mN_cyc_i` rises at edge t in IDLE → state OWNN after edge t+1. `s_cyc_o` is high during the cycle following edge t+1.
- Handover: owner cyc low sampled at edge t → the new owner drives the slave after edge t+1. There is no IDLE bubble.
- Data path adds zero latency while owned; the arbiter is purely combinational on the bus signals.
- `mN_err_o` is a single-cycle registered pulse.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined:
  - While in OWNN with `outst` > 0, the watchdog counts cycles without `s_ack_i`. Any ack resets it to 0.
  - On reaching `TIMEOUT_CYCLES − 1`: pulse `mN_err_o`, clear `outst`, go to DRAINN.
  - DRAINN forces the slave outputs to 0 and waits for `mN_cyc_i` = 0, then goes to IDLE.
- Undefined:
  - No watchdog logic and no DRAIN states are compiled.
  - `mN_err_o` is tied to 0.

## Test plan
- Single master write: m0 cyc/stb, addr 0, data 0x0000_1234, slave ack 3 cycles later → `s_cyc_o` high 1 cycle after the request; `m0_ack_o` is one pulse; m1 sees stall = 1 throughout.
- Contention after reset: m0 and m1 raise cyc in the same cycle → m0 granted first. On m0 release, m1 is granted with no IDLE cycle. Repeat with both raising cyc again → m0 then m1 (alternating).
- Read broadcast: m1 read of addr 0, slave returns 0x0000_000A with ack → `m1_ack_o` = 1 and `m1_data_o` = 0x0000_000A; `m0_ack_o` = 0.
- Outstanding saturation: m0 issues 8 stb beats with `s_ack_i` held low → 7 beats accepted, then `m0_stall_o` = 1. Ack 7 times, drop cyc → IDLE.
- Reset mid-cycle: `rst_i` pulsed while in OWN1 with `outst` = 2 → `s_cyc_o` = 0 the next cycle; a subsequent contention grants m0 first.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16: m0 stb accepted, ack never comes → `m0_err_o` pulses 16 cycles after acceptance and `s_cyc_o` goes to 0. The arbiter holds in DRAIN0 until `m0_cyc_i` goes low.

Source files
------------

// File: rtl/wb_sdram_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the SDRAM slave port.
// Optional ack watchdog with DRAIN states is built when WB_ARB_TIMEOUT_EN is defined.
module wb_sdram_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int OUTST_W        = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_stall_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_stall_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_stall_i,
    input  logic        s_ack_i
);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, OWN0, OWN1, DRAIN0, DRAIN1} state_t;
`else
    typedef enum logic [2:0] {IDLE, OWN0, OWN1} state_t;
`endif

    state_t             state;
    logic               last;
    logic [OUTST_W-1:0] outst;
    logic [OUTST_W-1:0] outst_nxt;
    logic               own0, own1, sat, inc, dec, pick0, pick1;

    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign sat   = &outst;
    assign pick0 = m0_cyc_i & (~m1_cyc_i | last);
    assign pick1 = m1_cyc_i & (~m0_cyc_i | ~last);

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    // A saturated counter also gates stb so the slave cannot take a beat the master thinks stalled
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_sel_o    = '0;
        s_addr_o   = '0;
        s_data_o   = '0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        if (own0) begin
            s_cyc_o    = m0_cyc_i;
            s_stb_o    = m0_cyc_i & m0_stb_i & ~sat;
            s_we_o     = m0_we_i;
            s_sel_o    = m0_sel_i;
            s_addr_o   = m0_addr_i;
            s_data_o   = m0_data_i;
            m0_stall_o = s_stall_i | sat;
            m0_ack_o   = s_ack_i;
        end else if (own1) begin
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_cyc_i & m1_stb_i & ~sat;
            s_we_o     = m1_we_i;
            s_sel_o    = m1_sel_i;
            s_addr_o   = m1_addr_i;
            s_data_o   = m1_data_i;
            m1_stall_o = s_stall_i | sat;
            m1_ack_o   = s_ack_i;
        end
    end

    assign inc = s_stb_o & ~s_stall_i;
    assign dec = (own0 | own1) & s_ack_i & (outst != '0);

    always_comb begin
        outst_nxt = outst;
        if (inc & ~dec)
            outst_nxt = outst + 1'b1;
        else if (dec & ~inc)
            outst_nxt = outst - 1'b1;
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd;
    logic            err0, err1, wd_run, wd_fire, wd_live;

    assign wd_live  = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign wd_run   = (outst != '0) & ~s_ack_i;
    assign wd_fire  = wd_live & wd_run & (wd == WD_LAST);
    assign m0_err_o = err0;
    assign m1_err_o = err1;
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign m0_err_o   = 1'b0;
    assign m1_err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            outst <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            wd    <= '0;
            err0  <= 1'b0;
            err1  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    outst <= '0;
                    unique case (1'b1)
                        pick0: begin
                            state <= OWN0;
                            last  <= 1'b0;
                        end
                        pick1: begin
                            state <= OWN1;
                            last  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        outst <= '0;
                        if (m1_cyc_i) begin
                            state <= OWN1;
                            last  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        outst <= outst_nxt;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        outst <= '0;
                        if (m0_cyc_i) begin
                            state <= OWN0;
                            last  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        outst <= outst_nxt;
                    end
                end
`ifdef WB_ARB_TIMEOUT_EN
                DRAIN0: if (!m0_cyc_i) state <= IDLE;
                DRAIN1: if (!m1_cyc_i) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            // Watchdog abort overrides the normal owner transition above
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (wd_fire) begin
                wd    <= '0;
                outst <= '0;
                err0  <= own0;
                err1  <= own1;
                if (own0)
                    state <= DRAIN0;
                else
                    state <= DRAIN1;
            end else if (wd_live & wd_run) begin
                wd <= wd + 1'b1;
            end else begin
                wd <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed self-checking bench for wb_sdram_arbiter.
// Watchdog scenario only runs when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_stall_o, m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_stall_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_stall_i, s_ack_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_sdram_arbiter #(
        .TIMEOUT_CYCLES(16),
        .OUTST_W       (3)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_sel_i  (m0_sel_i),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_data_o (m0_data_o),
        .m0_stall_o(m0_stall_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_sel_i  (m1_sel_i),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_data_o (m1_data_o),
        .m1_stall_o(m1_stall_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_stall_i (s_stall_i),
        .s_ack_i   (s_ack_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0;
        m0_addr_i = 0; m0_data_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0;
        m1_addr_i = 0; m1_data_i = 0;
        s_data_i = 0; s_stall_i = 0; s_ack_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        m0_cyc_i = 1;
        tick();
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_slave cyc=%b stb=%b exp 0 0", s_cyc_o, s_stb_o);
        end
        checks++;
        if (m0_stall_o !== 1'b1 || m1_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall m0=%b m1=%b exp 1 1", m0_stall_o, m1_stall_o);
        end
        checks++;
        if (m0_ack_o !== 1'b0 || m0_err_o !== 1'b0 || m1_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack_err ack=%b e0=%b e1=%b exp 0", m0_ack_o, m0_err_o, m1_err_o);
        end
        m0_cyc_i = 0;
        rst_i = 0;
        tick();
    endtask

    task automatic test_single_write();
        int acks = 0;
        logic m1_stalled = 1'b1;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_addr_i = 32'h0; m0_data_i = 32'h0000_1234;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL write_latency s_cyc=%b exp 0", s_cyc_o);
        end
        tick();
        #1;
        checks++;
        if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1 ||
            s_data_o !== 32'h0000_1234 || s_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL write_grant cyc=%b stb=%b we=%b data=%h sel=%h exp 1 1 1 00001234 f",
                     s_cyc_o, s_stb_o, s_we_o, s_data_o, s_sel_o);
        end
        checks++;
        if (m0_stall_o !== 1'b0 || m1_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL write_stall m0=%b m1=%b exp 0 1", m0_stall_o, m1_stall_o);
        end
        tick();
        m0_stb_i = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            s_ack_i = (i == 2);
            #1;
            if (m0_ack_o === 1'b1) acks++;
            if (m1_stall_o !== 1'b1 || m1_ack_o !== 1'b0) m1_stalled = 1'b0;
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL write_ack_pulses got=%0d exp 1", acks);
        end
        checks++;
        if (m1_stalled !== 1'b1) begin
            errors++;
            $display("FAIL write_m1_stall got=%b exp 1", m1_stalled);
        end
        tick();
        s_ack_i = 0;
        m0_cyc_i = 0;
        tick();
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || m0_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL write_release cyc=%b stall=%b exp 0 1", s_cyc_o, m0_stall_o);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        m0_addr_i = 32'h100;
        m1_addr_i = 32'h200;
        for (int r = 0; r < 2; r++) begin
            m0_cyc_i = 1;
            m1_cyc_i = 1;
            tick();
            #1;
            checks++;
            if (s_cyc_o !== 1'b1 || s_addr_o !== 32'h100 || m1_stall_o !== 1'b1) begin
                errors++;
                $display("FAIL contend_first_%0d cyc=%b addr=%h m1stall=%b exp 1 00000100 1",
                         r, s_cyc_o, s_addr_o, m1_stall_o);
            end
            tick();
            m0_cyc_i = 0;
            tick();
            #1;
            checks++;
            if (s_cyc_o !== 1'b1 || s_addr_o !== 32'h200 || m0_stall_o !== 1'b1) begin
                errors++;
                $display("FAIL contend_handover_%0d cyc=%b addr=%h m0stall=%b exp 1 00000200 1",
                         r, s_cyc_o, s_addr_o, m0_stall_o);
            end
            m1_cyc_i = 0;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_read_broadcast();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_addr_i = 0;
        tick();
        #1;
        checks++;
        if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL read_grant cyc=%b stb=%b we=%b exp 1 1 0", s_cyc_o, s_stb_o, s_we_o);
        end
        tick();
        m1_stb_i = 0;
        tick();
        s_ack_i = 1;
        s_data_i = 32'h0000_000A;
        #1;
        checks++;
        if (m1_ack_o !== 1'b1 || m1_data_o !== 32'h0000_000A) begin
            errors++;
            $display("FAIL read_m1 ack=%b data=%h exp 1 0000000a", m1_ack_o, m1_data_o);
        end
        checks++;
        if (m0_ack_o !== 1'b0 || m0_data_o !== 32'h0000_000A) begin
            errors++;
            $display("FAIL read_m0 ack=%b data=%h exp 0 0000000a", m0_ack_o, m0_data_o);
        end
        tick();
        s_ack_i = 0;
        m1_cyc_i = 0;
        tick();
        clear_inputs();
    endtask

    task automatic test_saturation();
        int acc = 0;
        int acks = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF; m0_addr_i = 32'h40;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            #1;
            if (s_stb_o === 1'b1 && s_stall_i === 1'b0) acc++;
        end
        checks++;
        if (acc != 7) begin
            errors++;
            $display("FAIL sat_accepted got=%0d exp 7", acc);
        end
        checks++;
        if (m0_stall_o !== 1'b1 || s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL sat_stall stall=%b stb=%b exp 1 0", m0_stall_o, s_stb_o);
        end
        tick();
        m0_stb_i = 0;
        s_ack_i = 1;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) tick();
            #1;
            if (m0_ack_o === 1'b1) acks++;
            if (j == 1) begin
                checks++;
                if (m0_stall_o !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_unstall stall=%b exp 0", m0_stall_o);
                end
            end
        end
        checks++;
        if (acks != 7) begin
            errors++;
            $display("FAIL sat_acks got=%0d exp 7", acks);
        end
        tick();
        s_ack_i = 0;
        m0_cyc_i = 0;
        tick();
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || m0_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_idle cyc=%b stall=%b exp 0 1", s_cyc_o, m0_stall_o);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_midcycle();
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h200;
        tick();
        tick();
        tick();
        m1_stb_i = 0;
        rst_i = 1;
        tick();
        rst_i = 0;
        m0_cyc_i = 1;
        m0_addr_i = 32'h300;
        s_ack_i = 1;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_cyc got=%b exp 0", s_cyc_o);
        end
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_late_ack m0=%b m1=%b exp 0 0", m0_ack_o, m1_ack_o);
        end
        tick();
        s_ack_i = 0;
        #1;
        checks++;
        if (s_cyc_o !== 1'b1 || s_addr_o !== 32'h300 || m1_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant cyc=%b addr=%h m1stall=%b exp 1 00000300 1",
                     s_cyc_o, s_addr_o, m1_stall_o);
        end
        clear_inputs();
        tick();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int found = 0;
        int pulses = 0;
        logic cyc_at = 1'b1;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h80;
        tick();
        tick();
        m0_stb_i = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (m0_err_o === 1'b1) begin
                pulses++;
                if (found == 0) begin
                    found = i;
                    cyc_at = s_cyc_o;
                end
            end
        end
        checks++;
        if (found != 16) begin
            errors++;
            $display("FAIL timeout_cycle got=%0d exp 16", found);
        end
        checks++;
        if (pulses != 1 || cyc_at !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse pulses=%0d cyc=%b exp 1 0", pulses, cyc_at);
        end
        checks++;
        if (s_cyc_o !== 1'b0 || m0_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_drain cyc=%b stall=%b exp 0 1", s_cyc_o, m0_stall_o);
        end
        m0_cyc_i = 0;
        tick();
        m1_cyc_i = 1;
        m1_addr_i = 32'h500;
        tick();
        #1;
        checks++;
        if (s_cyc_o !== 1'b1 || s_addr_o !== 32'h500) begin
            errors++;
            $display("FAIL timeout_recover cyc=%b addr=%h exp 1 00000500", s_cyc_o, s_addr_o);
        end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        rst_i = 1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_read_broadcast();
        test_saturation();
        test_reset_midcycle();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
